burst_gate: RTL and testbench
=============================

Name: burst_gate

Overview:
- Stage directly downstream of the 802.11 short-preamble plateau detector.
- Consumes the detector's per-sample trigger/phase stream in lockstep with the raw sample stream.
- On each trigger, emits one framed burst of BURST_LEN delayed samples, with the trigger's offset/phase attached.
- Pulses eof back to the detector when the burst ends, re-arming its search.

Parameters:
- WIDTH, 32: sample width (I/Q packed).
- DELAY_LEN, 32: samples of alignment delay between trigger and sample streams; power of 2, 2..256.
- BURST_LEN_W, 16: width of burst_len input.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush; same effect as reset
- burst_len  in  BURST_LEN_W  samples per burst; sampled at trigger; 0 treated as 1
- i_tdata  in  WIDTH  raw samples
- i_tvalid  in  1  raw samples valid
- i_tready  out  1  raw samples ready
- trig_tdata  in  32  {offset[31:16], phase[15:0]}
- trig_tlast  in  1  trigger flag
- trig_tvalid  in  1  trigger stream valid
- trig_tready  out  1  trigger stream ready
- o_tdata  out  WIDTH  gated samples
- o_tuser  out  32  latched {offset, phase}, constant across a burst
- o_tlast  out  1  last sample of burst
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- eof  out  1  one-cycle pulse on the cycle the o_tlast beat transfers
- dropped_triggers  out  16  saturating count of triggers ignored mid-burst

Behaviour:
- Reset/clear: o_tvalid=0, o_tlast=0, o_tdata=0, o_tuser=0, eof=0, dropped_triggers=0, fill count=0, burst counter=0, state=S_PRIME. Ring-buffer contents are don't-care.
- Join: a transfer happens when i_tvalid & trig_tvalid & adv.
  - adv = 1 in S_PRIME/S_IDLE; adv = output-stage ready in S_BURST/S_HDR-free cycles.
  - i_tready = trig_tready = trig_tvalid & i_tvalid & adv; both streams always move together.
- Delay line: DELAY_LEN-entry ring buffer, written on every transfer. Read sample = sample written DELAY_LEN transfers earlier.
- Output stage: 2-entry skid flop. o_* are registered. Latency is 1 clk from transfer to o_tvalid; full throughput with o_tready held high.
- States:
  - S_PRIME: transfers fill the ring; no output. After DELAY_LEN transfers, go to S_IDLE.
  - S_IDLE: delayed samples are discarded. On a transfer with trig_tlast=1:
    - latch trig_tdata into o_tuser register;
    - load count = max(burst_len,1);
    - go to S_BURST (or S_HDR with the feature below).
    - The delayed sample on the trigger beat is the first burst sample.
  - S_BURST: each transfer pushes one delayed sample and decrements count. When count==1, that beat has o_tlast=1, then go to S_IDLE.
    - trig_tlast=1 during S_BURST: ignored, dropped_triggers++ (saturates at 0xFFFF).
    - A trigger on the same beat as o_tlast is also dropped.
- eof: asserted for exactly one clk when the o_tlast beat is accepted (o_tvalid & o_tready & o_tlast), not when it is pushed.
- Backpressure: o_tready low stalls both inputs once the skid is full. No sample is lost or duplicated. Discarding in S_IDLE never stalls.
- reset or clear mid-burst: output is dropped immediately with no o_tlast; the block re-primes from S_PRIME.

Optional Feature:
- Macro BURST_GATE_CFO_HDR_EN.
- Defined:
  - S_HDR inserted after the trigger.
  - First output beat is a header: o_tdata = {offset, phase} zero-extended to WIDTH, o_tlast=0.
  - Inputs are stalled during the header beat.
  - Burst is BURST_LEN+1 beats; o_tuser is still driven.
- Undefined: no header; parameters live on o_tuser only.

Test Plan:
- Reset, DELAY_LEN=32, 40 beats with samples 0..39, no trigger, o_tready=1 → no o_tvalid; i_tready high throughout.
- Samples n=0..199, trigger on beat 100 with trig_tdata=0x0005_1234, burst_len=4 → o_tdata 68,69,70,71; o_tlast on 71; o_tuser=0x00051234; eof one clk on the 71 beat.
- Same burst with o_tready toggling 1,0,0,1 → identical 4 samples, in order; i_tready low while stalled.
- Second trigger on beat 102 during that burst → ignored; dropped_triggers=1; only one o_tlast.
- clear asserted after 2 burst beats → no o_tlast; a later trigger needs 32 new beats of priming first.
- With BURST_GATE_CFO_HDR_EN, burst_len=2 → beats: 0x00051234, 68, 69(tlast).

Source files
------------

// File: rtl/burst_gate.sv
`default_nettype none
// ============================================================================
// Module   : burst_gate
// Purpose  : Aligns samples to the trigger stream through a DELAY_LEN ring and
//            frames one burst of delayed samples per trigger.
//            Define BURST_GATE_CFO_HDR_EN to prepend an {offset, phase} header beat.
// Revision : 1.0 - initial release
// ============================================================================
module burst_gate #(
   parameter int WIDTH       = 32,
   parameter int DELAY_LEN   = 32,
   parameter int BURST_LEN_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic [BURST_LEN_W-1:0] burst_len,
   input  logic [WIDTH-1:0]       i_tdata,
   input  logic                   i_tvalid,
   output logic                   i_tready,
   input  logic [31:0]            trig_tdata,
   input  logic                   trig_tlast,
   input  logic                   trig_tvalid,
   output logic                   trig_tready,
   output logic [WIDTH-1:0]       o_tdata,
   output logic [31:0]            o_tuser,
   output logic                   o_tlast,
   output logic                   o_tvalid,
   input  logic                   o_tready,
   output logic                   eof,
   output logic [15:0]            dropped_triggers
);

   localparam int PTR_W = $clog2(DELAY_LEN);
   localparam logic [PTR_W-1:0]       c_ptr_last = PTR_W'(DELAY_LEN - 1);
   localparam logic [PTR_W-1:0]       c_ptr_one  = PTR_W'(1);
   localparam logic [BURST_LEN_W-1:0] c_one      = BURST_LEN_W'(1);

   typedef enum logic [2:0] {
      S_PRIME = 3'd0,
      S_IDLE  = 3'd1,
      S_BURST = 3'd2,
      S_HDR   = 3'd3,
      S_FIRST = 3'd4
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic                   w_rst;
   logic                   w_adv;
   logic                   w_xfer;
   logic [PTR_W-1:0]       r_wp;
   logic [WIDTH-1:0]       r_mem [DELAY_LEN];
   logic [WIDTH-1:0]       w_rd;
   logic [31:0]            r_user;
   logic [BURST_LEN_W-1:0] r_cnt;
   logic [BURST_LEN_W-1:0] w_cnt;
   logic [BURST_LEN_W-1:0] w_len;
   logic                   w_latch;
   logic                   w_drop;
   logic                   w_push;
   logic [WIDTH-1:0]       w_pd;
   logic [31:0]            w_pu;
   logic                   w_pl;
   logic                   w_pop;
   logic                   r_v0;
   logic                   r_v1;
   logic [WIDTH-1:0]       r_d0;
   logic [WIDTH-1:0]       r_d1;
   logic [31:0]            r_u0;
   logic [31:0]            r_u1;
   logic                   r_l0;
   logic                   r_l1;
   logic [15:0]            r_drop;
`ifdef BURST_GATE_CFO_HDR_EN
   logic [WIDTH-1:0]       r_pend;
`endif

   assign w_rst = reset | clear;
   assign w_len = (burst_len == '0) ? c_one : burst_len;
   assign w_rd  = r_mem[r_wp];

   // The skid's second slot being occupied is the only reason to refuse a push.
   always_comb begin
      w_adv = 1'b0;
      case (r_state)
         S_PRIME: w_adv = 1'b1;
`ifdef BURST_GATE_CFO_HDR_EN
         S_IDLE:  w_adv = 1'b1;
`else
         S_IDLE:  w_adv = !(trig_tlast && r_v1);
`endif
         S_BURST: w_adv = !r_v1;
         default: w_adv = 1'b0;
      endcase
   end

   assign w_xfer      = i_tvalid & trig_tvalid & w_adv;
   assign i_tready    = w_xfer;
   assign trig_tready = w_xfer;

   always_comb begin
      w_next  = r_state;
      w_cnt   = r_cnt;
      w_push  = 1'b0;
      w_pd    = w_rd;
      w_pu    = r_user;
      w_pl    = 1'b0;
      w_latch = 1'b0;
      w_drop  = 1'b0;
      case (r_state)
         S_PRIME: begin
            if (w_xfer && (r_wp == c_ptr_last)) w_next = S_IDLE;
         end
         S_IDLE: begin
            if (w_xfer && trig_tlast) begin
               w_latch = 1'b1;
`ifdef BURST_GATE_CFO_HDR_EN
               w_cnt   = w_len;
               w_next  = S_HDR;
`else
               w_push  = 1'b1;
               w_pu    = trig_tdata;
               w_pl    = (w_len == c_one);
               w_cnt   = w_len - c_one;
               w_next  = (w_len == c_one) ? S_IDLE : S_BURST;
`endif
            end
         end
`ifdef BURST_GATE_CFO_HDR_EN
         S_HDR: begin
            if (!r_v1) begin
               w_push = 1'b1;
               w_pd   = WIDTH'(r_user);
               w_next = S_FIRST;
            end
         end
         // Replays the sample captured on the trigger beat, after the header.
         S_FIRST: begin
            if (!r_v1) begin
               w_push = 1'b1;
               w_pd   = r_pend;
               w_pl   = (r_cnt == c_one);
               w_cnt  = r_cnt - c_one;
               w_next = (r_cnt == c_one) ? S_IDLE : S_BURST;
            end
         end
`endif
         S_BURST: begin
            if (w_xfer) begin
               w_push = 1'b1;
               w_pl   = (r_cnt == c_one);
               w_cnt  = r_cnt - c_one;
               w_drop = trig_tlast;
               if (r_cnt == c_one) w_next = S_IDLE;
            end
         end
         default: w_next = S_PRIME;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_xfer) r_mem[r_wp] <= i_tdata;
   end

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_state <= S_PRIME;
         r_wp    <= '0;
         r_cnt   <= '0;
         r_user  <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt;
         if (w_xfer) r_wp <= r_wp + c_ptr_one;
         if (w_latch) r_user <= trig_tdata;
      end
   end

`ifdef BURST_GATE_CFO_HDR_EN
   always_ff @(posedge clk) begin
      if (w_latch) r_pend <= w_rd;
   end
`endif

   assign w_pop = r_v0 & o_tready;

   // Slot 0 drives the outputs; slot 1 only fills while the consumer stalls.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_v0 <= 1'b0;
         r_v1 <= 1'b0;
         r_d0 <= '0;
         r_d1 <= '0;
         r_u0 <= '0;
         r_u1 <= '0;
         r_l0 <= 1'b0;
         r_l1 <= 1'b0;
      end else if (w_pop && r_v1) begin
         r_d0 <= r_d1;
         r_u0 <= r_u1;
         r_l0 <= r_l1;
         r_v1 <= 1'b0;
      end else if (w_pop) begin
         if (w_push) begin
            r_d0 <= w_pd;
            r_u0 <= w_pu;
            r_l0 <= w_pl;
         end else begin
            r_v0 <= 1'b0;
            r_l0 <= 1'b0;
         end
      end else if (w_push) begin
         if (!r_v0) begin
            r_d0 <= w_pd;
            r_u0 <= w_pu;
            r_l0 <= w_pl;
            r_v0 <= 1'b1;
         end else begin
            r_d1 <= w_pd;
            r_u1 <= w_pu;
            r_l1 <= w_pl;
            r_v1 <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_drop <= '0;
      end else if (w_drop && (r_drop != 16'hFFFF)) begin
         r_drop <= r_drop + 16'd1;
      end
   end

   assign o_tdata          = r_d0;
   assign o_tuser          = r_u0;
   assign o_tlast          = r_l0;
   assign o_tvalid         = r_v0;
   assign eof              = w_pop & r_l0;
   assign dropped_triggers = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_burst_gate.sv
`default_nettype none
// tb_burst_gate: directed and randomized streams scored against a
// sample-history reference model through an expected-beat queue.
module tb_burst_gate;
   localparam int WIDTH     = 32;
   localparam int DELAY_LEN = 32;
`ifdef BURST_GATE_CFO_HDR_EN
   localparam int DIR_BL    = 2;
`else
   localparam int DIR_BL    = 4;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             clear;
   logic [15:0]      burst_len;
   logic [WIDTH-1:0] i_tdata;
   logic             i_tvalid;
   logic             i_tready;
   logic [31:0]      trig_tdata;
   logic             trig_tlast;
   logic             trig_tvalid;
   logic             trig_tready;
   logic [WIDTH-1:0] o_tdata;
   logic [31:0]      o_tuser;
   logic             o_tlast;
   logic             o_tvalid;
   logic             o_tready;
   logic             eof;
   logic [15:0]      dropped_triggers;

   burst_gate #(.WIDTH(WIDTH), .DELAY_LEN(DELAY_LEN), .BURST_LEN_W(16)) dut (
      .clk(clk), .reset(reset), .clear(clear), .burst_len(burst_len),
      .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .trig_tdata(trig_tdata), .trig_tlast(trig_tlast), .trig_tvalid(trig_tvalid),
      .trig_tready(trig_tready), .o_tdata(o_tdata), .o_tuser(o_tuser),
      .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready), .eof(eof),
      .dropped_triggers(dropped_triggers)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [31:0]      user;
      logic             last;
   } beat_t;

   beat_t            exp_q[$];
   logic [WIDTH-1:0] hist[$];
   logic [WIDTH-1:0] seen_q[$];
   int               checks = 0;
   int               errors = 0;
   int               rem = 0;
   int               drops_exp = 0;
   int               tlast_cnt = 0;
   int               stall_cycles = 0;
   int               ot_mode = 0;
   logic [1:0]       ot_phase = 2'd0;
   logic [3:0]       ot_pat = 4'b1001;
   logic [31:0]      cur_user = 32'd0;
   logic [WIDTH-1:0] m_dly;
   beat_t            m_b;
   beat_t            m_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Reference model: delayed sample is the one seen DELAY_LEN handshakes ago.
   always @(negedge clk) begin
      if (reset || clear) begin
         exp_q.delete();
         hist.delete();
         rem = 0;
         drops_exp = 0;
      end else if (i_tvalid && trig_tvalid && i_tready) begin
         hist.push_back(i_tdata);
         if (hist.size() > DELAY_LEN) begin
            m_dly = hist.pop_front();
            if (rem == 0) begin
               if (trig_tlast) begin
                  cur_user = trig_tdata;
                  rem = (burst_len == 16'd0) ? 1 : int'(burst_len);
`ifdef BURST_GATE_CFO_HDR_EN
                  m_b.data = WIDTH'(trig_tdata);
                  m_b.user = trig_tdata;
                  m_b.last = 1'b0;
                  exp_q.push_back(m_b);
`endif
               end
            end else if (trig_tlast) begin
               drops_exp = (drops_exp == 65535) ? 65535 : drops_exp + 1;
            end
            if (rem > 0) begin
               rem--;
               m_b.data = m_dly;
               m_b.user = cur_user;
               m_b.last = (rem == 0);
               exp_q.push_back(m_b);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!(reset || clear)) begin
         if (o_tvalid && o_tready) begin
            seen_q.push_back(o_tdata);
            if (o_tlast) tlast_cnt++;
            if (exp_q.size() == 0) begin
               check("spurious_beat", 64'(o_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               m_e = exp_q.pop_front();
               check("o_tdata", 64'(o_tdata), 64'(m_e.data));
               check("o_tuser", 64'(o_tuser), 64'(m_e.user));
               check("o_tlast", 64'(o_tlast), 64'(m_e.last));
               check("eof", 64'(eof), 64'(m_e.last));
            end
         end else if (eof) begin
            check("eof_no_xfer", 64'(eof), 64'd0);
         end
      end
   end

   initial begin
      o_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ot_mode)
            1: begin
               o_tready = ot_pat[ot_phase];
               ot_phase = ot_phase + 2'd1;
            end
            2: o_tready = ($urandom_range(0, 3) != 0);
            default: o_tready = 1'b1;
         endcase
      end
   end

   task automatic send_beat(input logic [WIDTH-1:0] d, input logic tl,
                            input logic [31:0] td, input logic [15:0] bl);
      int  waited = 0;
      bit  done = 0;
      i_tdata = d; trig_tdata = td; trig_tlast = tl; burst_len = bl;
      i_tvalid = 1'b1; trig_tvalid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (i_tready) begin
            done = 1;
         end else begin
            stall_cycles++;
            waited++;
            if (waited > 200) begin
               checks++; errors++;
               $display("FAIL accept_timeout actual=stalled required=accepted");
               done = 1;
            end
         end
         @(posedge clk); #1;
      end
      i_tvalid = 1'b0; trig_tvalid = 1'b0; trig_tlast = 1'b0;
   endtask

   task automatic run_stream(input int n, input int t1, input int t2,
                             input logic [15:0] bl, input logic [31:0] td);
      for (int k = 0; k < n; k++) begin
         if (k == t1 || k == t2) send_beat(WIDTH'(k), 1'b1, td, bl);
         else                    send_beat(WIDTH'(k), 1'b0, $urandom, bl);
      end
   endtask

   task automatic drain(input string name);
      int w = 0;
      while (exp_q.size() != 0 && w < 500) begin
         @(posedge clk);
         w++;
      end
      repeat (4) @(posedge clk);
      #1;
      check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
      check({name, "_idle"}, 64'(o_tvalid), 64'd0);
   endtask

   task automatic pulse(input bit is_clear);
      if (is_clear) clear = 1'b1; else reset = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; reset = 1'b0;
      seen_q.delete(); tlast_cnt = 0; stall_cycles = 0;
   endtask

   task automatic check_seen(input string name, input int base, input int n);
      logic [WIDTH-1:0] want[$];
`ifdef BURST_GATE_CFO_HDR_EN
      want.push_back(WIDTH'(32'h0005_1234));
`endif
      for (int k = 0; k < n; k++) want.push_back(WIDTH'(base + k));
      check({name, "_count"}, 64'(seen_q.size()), 64'(want.size()));
      for (int k = 0; k < want.size() && k < seen_q.size(); k++)
         check(name, 64'(seen_q[k]), 64'(want[k]));
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; burst_len = 16'd0;
      i_tdata = '0; i_tvalid = 1'b0; trig_tdata = '0; trig_tlast = 1'b0; trig_tvalid = 1'b0;
      repeat (3) @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_o_tvalid", 64'(o_tvalid), 64'd0);
      check("rst_o_tlast", 64'(o_tlast), 64'd0);
      check("rst_o_tdata", 64'(o_tdata), 64'd0);
      check("rst_o_tuser", 64'(o_tuser), 64'd0);
      check("rst_eof", 64'(eof), 64'd0);
      check("rst_dropped", 64'(dropped_triggers), 64'd0);
      @(posedge clk); #1;

      // Priming only: no output, never stalled
      pulse(0);
      run_stream(40, -1, -1, 16'd4, 32'd0);
      drain("prime");
      check("prime_stalls", 64'(stall_cycles), 64'd0);
      check("prime_beats", 64'(seen_q.size()), 64'd0);

      // Single burst, free-running consumer
      pulse(0);
      run_stream(200, 100, -1, 16'(DIR_BL), 32'h0005_1234);
      drain("burst");
      check_seen("burst", 68, DIR_BL);
      check("burst_tlast_cnt", 64'(tlast_cnt), 64'd1);

      // Same burst with o_tready pattern 1,0,0,1
      pulse(0);
      ot_mode = 1;
      run_stream(200, 100, -1, 16'(DIR_BL), 32'h0005_1234);
      drain("bp");
      ot_mode = 0;
      check_seen("bp", 68, DIR_BL);
      check("bp_stalled", 64'(stall_cycles > 0), 64'd1);

      // Second trigger inside the burst is dropped
      pulse(0);
      run_stream(200, 100, 102, 16'd4, 32'h0005_1234);
      drain("drop");
      check_seen("drop", 68, 4);
      check("drop_count", 64'(dropped_triggers), 64'd1);
      check("drop_tlast_cnt", 64'(tlast_cnt), 64'd1);

      // Clear mid-burst, then re-prime before the next trigger takes effect
      pulse(0);
      run_stream(102, 100, -1, 16'd4, 32'h0005_1234);
      pulse(1);
      repeat (3) @(posedge clk); #1;
      check("clear_no_tlast", 64'(tlast_cnt), 64'd0);
      run_stream(60, 10, 50, 16'd4, 32'h0005_1234);
      drain("reprime");
      check_seen("reprime", 18, 4);
      check("reprime_drops", 64'(dropped_triggers), 64'd0);

      // Randomized traffic, backpressure, bubbles and occasional clear
      pulse(0);
      ot_mode = 2;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            i_tvalid = 1'($urandom_range(0, 1));
            trig_tvalid = ~i_tvalid & 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            i_tvalid = 1'b0; trig_tvalid = 1'b0;
         end
         if ($urandom_range(0, 499) == 0) pulse(1);
         send_beat($urandom, ($urandom_range(0, 19) == 0), $urandom, 16'($urandom_range(0, 12)));
      end
      drain("random");
      check("random_drops", 64'(dropped_triggers), 64'(drops_exp));
      ot_mode = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
